// File: rtl/radar_pkg.sv
// Shared definitions for the radar display chain: segment codes, the BCD
// converter state type and the nibble-to-segment decoder.
package radar_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Segment order is {a,b,c,d,e,f,g}, active-high; non-decimal nibbles go dark.
  function automatic logic [6:0] seg7_code(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg7_code = 7'b1111110;
      4'd1:    seg7_code = 7'b0110000;
      4'd2:    seg7_code = 7'b1101101;
      4'd3:    seg7_code = 7'b1111001;
      4'd4:    seg7_code = 7'b0110011;
      4'd5:    seg7_code = 7'b1011011;
      4'd6:    seg7_code = 7'b1011111;
      4'd7:    seg7_code = 7'b1110000;
      4'd8:    seg7_code = 7'b1111111;
      4'd9:    seg7_code = 7'b1111011;
      default: seg7_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with input saturation and a one-deep
// pending sample; only complete results are committed to bcd/ovr.
module bin2bcd_seq
  import radar_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      din,
  input  logic                  din_valid,
  output logic                  busy,
  output logic                  ovr,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int          MAX_VAL = 10**DIGITS - 1;
  localparam logic [31:0] MAX_U   = 32'(MAX_VAL);
  localparam int          CNT_W   = $clog2(BIN_W + 1);

  conv_state_e state_q, state_d;

  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BIN_W-1:0]    pend_val_q, pend_val_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] work_q, work_d, work_adj;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovr_pend_q, ovr_pend_d;
  logic                ovr_q, ovr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                start;
  logic [BIN_W-1:0]    start_val;
  logic                start_over;

  // A fresh strobe in IDLE takes priority over the held pending sample.
  assign start      = (state_q == ST_IDLE) && (din_valid || pend_vld_q);
  assign start_val  = din_valid ? din : pend_val_q;
  assign start_over = 32'(start_val) > MAX_U;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                 work_q[4*gi +: 4] + 4'd3 : work_q[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    bin_d      = bin_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovr_pend_d = ovr_pend_q;
    bcd_d      = bcd_q;
    ovr_d      = ovr_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;

    if (state_q != ST_IDLE && din_valid) begin
      pend_vld_d = 1'b1;
      pend_val_d = din;
    end else if (start) begin
      pend_vld_d = 1'b0;
    end

    if (start) begin
      bin_d      = start_over ? BIN_W'(MAX_VAL) : start_val;
      work_d     = '0;
      cnt_d      = '0;
      ovr_pend_d = start_over;
    end else if (state_q == ST_SHIFT) begin
      {work_d, bin_d} = {work_adj, bin_q} << 1;
      cnt_d           = cnt_q + CNT_W'(1);
    end else if (state_q == ST_DONE) begin
      bcd_d = work_q;
      ovr_d = ovr_pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovr_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovr_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      bin_q      <= bin_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovr_pend_q <= ovr_pend_d;
      bcd_q      <= bcd_d;
      ovr_q      <= ovr_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign bcd = bcd_q;
  assign ovr = ovr_q;

endmodule

// File: rtl/distance_display.sv
// Radar distance display: BCD conversion plus a multiplexed 7-segment scanner
// with leading-zero blanking, over-range dashes and an anti-ghost gap.
module distance_display
  import radar_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int DIGITS     = 4,
  parameter int BIN_W      = 14,
  parameter int LZ_BLANK   = 1,
  parameter int DIG_ACT_LO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIN_W-1:0]    dist_cm,
  input  logic                dist_valid,
  output logic                busy,
  output logic                over_range,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   dig_sel
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LO != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] bcd_w;
  logic                ovr_w;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (dist_cm),
    .din_valid (dist_valid),
    .busy      (busy),
    .ovr       (ovr_w),
    .bcd       (bcd_w)
  );

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              run_q, run_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic              wrap;
  logic [3:0]        nib;
  logic [DIGITS-1:0] upper_nz;

  assign wrap = (presc_q == PW'(DIV - 1));
  assign nib  = bcd_w[4*idx_q +: 4];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper
    assign upper_nz[gi] = |bcd_w[4*DIGITS-1:4*gi];
  end

  // Scanning stays dark until the first prescaler wrap so digit 0 comes up first.
  always_comb begin
    presc_d = wrap ? PW'(0) : presc_q + PW'(1);
    run_d   = run_q | wrap;
    idx_d   = idx_q;
    if (wrap && run_q) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? IW'(0) : idx_q + IW'(1);
    end

    seg_d = SEG_BLANK;
    dig_d = DIG_OFF;
    if (run_q && !wrap) begin
      dig_d = DIG_OFF ^ (DIGITS'(1) << idx_q);
      if (ovr_w) begin
        seg_d = SEG_DASH;
      end else if (LZ_BLANK != 0 && idx_q != IW'(0) && !upper_nz[idx_q]) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = seg7_code(nib);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      dig_q   <= DIG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign bcd_out    = bcd_w;
  assign over_range = ovr_w;

endmodule

// File: tb/tb_distance_display.sv
// Directed bench for distance_display at 4 clocks per digit dwell.
module tb_distance_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] dist_cm = '0;
  logic        dist_valid = 1'b0;
  logic        busy;
  logic        over_range;
  logic [15:0] bcd_out;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] last_bcd = 16'h0000;

  distance_display #(
    .CLK_HZ     (1000),
    .SCAN_HZ    (250),
    .DIGITS     (4),
    .BIN_W      (14),
    .LZ_BLANK   (1),
    .DIG_ACT_LO (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .busy       (busy),
    .over_range (over_range),
    .bcd_out    (bcd_out),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [6:0] exp_seg(input int val, input int d, input logic ovr);
    int p;
    int dg;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (ovr) return 7'b0000001;
    if (d > 0 && val < p) return 7'b0000000;
    dg = (val / p) % 10;
    case (dg)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] exp_dig(input int d);
    case (d)
      0: return 4'hE;
      1: return 4'hD;
      2: return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  // cyc counts negedges since reset release; first digit lit at cyc DIV+1,
  // then three lit cycles and one dark cycle per digit.
  task automatic scan_check(input int ncyc, input int val, input logic ovr);
    int d;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (cyc < DIV + 1 || ((cyc - DIV - 1) % DIV) == DIV - 1) begin
        check("dig_sel_off", dig_sel, 4'hF);
        check("seg_off", seg_out, 7'b0);
      end else begin
        d = ((cyc - DIV - 1) / DIV) % 4;
        check("dig_sel", dig_sel, exp_dig(d));
        check("seg_out", seg_out, exp_seg(val, d, ovr));
      end
    end
  endtask

  task automatic convert(input int val, input logic [15:0] exp_bcd, input logic exp_ovr);
    dist_cm = 14'(val);
    dist_valid = 1'b1;
    tick();
    dist_valid = 1'b0;
    check("busy_t1", busy, 1);
    repeat (13) tick();
    tick();
    check("busy_t15", busy, 1);
    check("bcd_hold_t15", bcd_out, last_bcd);
    tick();
    check("busy_t16", busy, 0);
    check("bcd_t16", bcd_out, exp_bcd);
    check("ovr_t16", over_range, exp_ovr);
    last_bcd = exp_bcd;
    $display("convert %0d -> bcd %h ovr %0b", val, bcd_out, over_range);
  endtask

  initial begin
    // 1: reset state, then idle scan of "0"
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ovr", over_range, 0);
    check("rst_bcd", bcd_out, 16'h0);
    check("rst_seg", seg_out, 7'b0);
    check("rst_dig", dig_sel, 4'hF);
    rst_n = 1'b1;
    cyc = 0;
    scan_check(24, 0, 1'b0);
    $display("reset scan done, %0d compares so far", n_cmp);

    // 2: plain conversion
    convert(1234, 16'h1234, 1'b0);
    scan_check(16, 1234, 1'b0);

    // 3: saturation, then recovery
    convert(12000, 16'h9999, 1'b1);
    scan_check(16, 9999, 1'b1);
    convert(7, 16'h0007, 1'b0);
    scan_check(16, 7, 1'b0);

    // 4: strobes while busy, last pending wins
    dist_cm = 14'd50; dist_valid = 1'b1; tick(); dist_valid = 1'b0;
    tick();
    dist_cm = 14'd60; dist_valid = 1'b1; tick(); dist_valid = 1'b0;
    tick();
    dist_cm = 14'd70; dist_valid = 1'b1; tick(); dist_valid = 1'b0;
    repeat (11) tick();
    check("pend_bcd50", bcd_out, 16'h0050);
    check("pend_idle_busy", busy, 0);
    tick();
    check("pend_restart_busy", busy, 1);
    for (int i = 18; i <= 31; i++) begin
      tick();
      check("pend_no60", bcd_out, 16'h0050);
    end
    tick();
    check("pend_bcd70", bcd_out, 16'h0070);
    check("pend_done_busy", busy, 0);
    last_bcd = 16'h0070;
    $display("pending 50/60/70 -> bcd %h", bcd_out);

    // 5: reset in the middle of converting 900
    dist_cm = 14'd900; dist_valid = 1'b1; tick(); dist_valid = 1'b0;
    repeat (4) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", bcd_out, 16'h0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dig", dig_sel, 4'hF);
    check("mid_rst_seg", seg_out, 7'b0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
    last_bcd = 16'h0000;
    scan_check(24, 0, 1'b0);
    check("post_rst_bcd", bcd_out, 16'h0);
    check("post_rst_busy", busy, 0);
    $display("reset mid-conversion -> bcd %h busy %0b", bcd_out, busy);

    // 6: boundaries
    convert(0, 16'h0000, 1'b0);
    scan_check(16, 0, 1'b0);
    convert(9999, 16'h9999, 1'b0);
    scan_check(16, 9999, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
